// File: rtl/ddr_wr_burst_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr_wr_burst_ctrl_pkg
//   Shared constants for the DDR write burst controller: FSM state
//   encodings and AXI data-path geometry (256-bit beats, 32 bytes each).
// ---------------------------------------------------------------------------
package ddr_wr_burst_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AW   = 2'd1;
  localparam logic [1:0] ST_W    = 2'd2;
  localparam logic [1:0] ST_B    = 2'd3;

  localparam int AXI_DATA_W = 256;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int BEAT_BYTES = 32;

endpackage

// File: rtl/ddr_wr_burst_ctrl_skid.sv
// ---------------------------------------------------------------------------
// ddr_wr_skid
//   Two-entry 256-bit skid FIFO between the write-FIFO read port and the
//   AXI W channel. Absorbs words already requested from the write FIFO
//   while wready is low.
// Ports
//   ddr_clk    in   clock
//   rstn       in   async active-low reset (pointers/count only)
//   push       in   write enable (delayed write-FIFO rd_req)
//   push_data  in   256-bit word from the write FIFO
//   pop        in   read enable (W handshake)
//   head_data  out  oldest stored word
//   count      out  number of stored words, 0..2
// ---------------------------------------------------------------------------
module ddr_wr_skid
  import ddr_wr_burst_ctrl_pkg::*;
(
  input  logic                  ddr_clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [AXI_DATA_W-1:0] push_data,
  input  logic                  pop,
  output logic [AXI_DATA_W-1:0] head_data,
  output logic [1:0]            count
);

  logic [AXI_DATA_W-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset; count says which entries are meaningful.
  always_ff @(posedge ddr_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_wr_burst_ctrl
//   DDR write master on the ddr_clk side of the video frame buffer. Drains
//   the write FIFO in fixed AXI4 INCR bursts once a full burst is buffered,
//   ping-pongs whole frames between two buffers and publishes the index of
//   the last completely written frame.
// Ports
//   ddr_clk, rstn               clock, async active-low reset
//   vs_in                       async input vsync (rising edge = new frame)
//   wfifo_rd_water_level [8:0]  write-FIFO read-side fill in 256-bit words
//   wfifo_rd_req                write-FIFO read enable, data one cycle later
//   wfifo_rd_data256_in         write-FIFO read data
//   axi_aw*/axi_w*/axi_b*       AXI4 write address/data/response channels
//   wr_frame_idx                buffer index of last fully written frame
// ---------------------------------------------------------------------------
module ddr_wr_burst_ctrl
  import ddr_wr_burst_ctrl_pkg::*;
#(
  parameter int          BURST_LEN    = 16,
  parameter int          ADDR_W       = 28,
  parameter int          FRAME_BEATS  = 259200,
  parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000,
  parameter int          HOLDOFF      = 32
) (
  input  logic                  ddr_clk,
  input  logic                  rstn,
  input  logic                  vs_in,
  input  logic [8:0]            wfifo_rd_water_level,
  output logic                  wfifo_rd_req,
  input  logic [AXI_DATA_W-1:0] wfifo_rd_data256_in,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [AXI_DATA_W-1:0] axi_wdata,
  output logic [AXI_STRB_W-1:0] axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic                  wr_frame_idx
);

  localparam int OFF_W = $clog2(FRAME_BEATS + 1);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int HO_W  = $clog2(HOLDOFF + 2);

  localparam logic [OFF_W-1:0] FRAME_END  = OFF_W'(FRAME_BEATS);
  localparam logic [OFF_W-1:0] OFF_STEP   = OFF_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [8:0]       BURST_WL   = 9'(BURST_LEN);
  localparam logic [HO_W-1:0]  HOLDOFF_LD = HO_W'(HOLDOFF);

  // Burst start address, computed at ADDR_W so the sum wraps naturally.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic buf_sel,
                                                   input logic [OFF_W-1:0] off);
    logic [ADDR_W-1:0] base;
    base = buf_sel ? ADDR_W'(FRAME_STRIDE) : '0;
    return base + ADDR_W'(off) * ADDR_W'(BEAT_BYTES);
  endfunction

  logic                  vs_p0, vs_p1, vs_p2;
  logic                  vs_pulse;
  logic                  resync_pend;
  logic                  do_resync;
  logic                  start_burst;
  logic [1:0]            state;
  logic [OFF_W-1:0]      offset;
  logic                  cur_buf;
  logic [HO_W-1:0]       holdoff;
  logic [CNT_W-1:0]      reads_issued;
  logic [CNT_W-1:0]      beats_sent;
  logic                  vld_p1;
  logic [1:0]            skid_count;
  logic [AXI_DATA_W-1:0] skid_head;
  logic                  w_hs;

  // Stage p0..p2: vsync synchroniser and rising-edge history
  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      vs_p0 <= vs_in;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign vs_pulse = vs_p1 & ~vs_p2;

  // A pulse arriving in IDLE is serviced at once, so it also blocks a burst
  // start decided in the same cycle.
  assign do_resync   = (state == ST_IDLE) && (resync_pend || vs_pulse);
  assign start_burst = (state == ST_IDLE) && !resync_pend && !vs_pulse &&
                       (holdoff == '0) &&
                       (wfifo_rd_water_level >= BURST_WL) &&
                       (offset < FRAME_END);

  assign w_hs = axi_wvalid && axi_wready;

  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      resync_pend  <= 1'b0;
      holdoff      <= '0;
      offset       <= '0;
      cur_buf      <= 1'b0;
      wr_frame_idx <= 1'b1;
      axi_awaddr   <= '0;
      reads_issued <= '0;
      beats_sent   <= '0;
    end else begin
      if (do_resync)     resync_pend <= 1'b0;
      else if (vs_pulse) resync_pend <= 1'b1;

      if (do_resync)            holdoff <= HOLDOFF_LD;
      else if (holdoff != '0)   holdoff <= holdoff - HO_W'(1);

      if (do_resync) begin
        offset <= '0;
        if (offset == FRAME_END) begin
          wr_frame_idx <= cur_buf;
          cur_buf      <= ~cur_buf;
        end
      end else if (state == ST_B && axi_bvalid) begin
        offset <= offset + OFF_STEP;
      end

      if (start_burst) begin
        axi_awaddr   <= burst_addr(cur_buf, offset);
        reads_issued <= '0;
        beats_sent   <= '0;
      end else begin
        if (wfifo_rd_req) reads_issued <= reads_issued + CNT_W'(1);
        if (w_hs)         beats_sent   <= beats_sent + CNT_W'(1);
      end

      case (state)
        ST_IDLE: if (start_burst)             state <= ST_AW;
        ST_AW:   if (axi_awready)             state <= ST_W;
        ST_W:    if (w_hs && axi_wlast)       state <= ST_B;
        default: if (axi_bvalid)              state <= ST_IDLE;
      endcase
    end
  end

  // Reads start once the burst is committed and never outrun the skid space
  // (words in the skid plus the one still in flight from the FIFO).
  assign wfifo_rd_req = ((state == ST_AW) || (state == ST_W)) &&
                        (reads_issued < BURST_CNT) &&
                        (({1'b0, skid_count} + {2'b00, vld_p1}) < 3'd2);

  // Stage p1: write-FIFO read data valid one cycle after rd_req
  always_ff @(posedge ddr_clk or negedge rstn) begin
    if (!rstn) vld_p1 <= 1'b0;
    else       vld_p1 <= wfifo_rd_req;
  end

  ddr_wr_skid u_skid (
    .ddr_clk   (ddr_clk),
    .rstn      (rstn),
    .push      (vld_p1),
    .push_data (wfifo_rd_data256_in),
    .pop       (w_hs),
    .head_data (skid_head),
    .count     (skid_count)
  );

  // Skid content only leaves on a handshake, so wvalid cannot drop and
  // wdata cannot change while the slave stalls.
  assign axi_awvalid = (state == ST_AW);
  assign axi_awlen   = 8'(BURST_LEN - 1);
  assign axi_wvalid  = (state == ST_W) && (skid_count != 2'd0);
  assign axi_wdata   = skid_head;
  assign axi_wstrb   = '1;
  assign axi_wlast   = axi_wvalid && (beats_sent == LAST_BEAT);
  assign axi_bready  = (state == ST_B);

endmodule
